// File: rtl/cpu_mul_pkg.sv
// Shared definitions for the sequential multiply front-end (op encoding, FSM states, widths).
// Latency: none; declarations only.
// Backpressure: not applicable.
package cpu_mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULXUU = 2'd1,
    MUL_OP_MULXSS = 2'd2,
    MUL_OP_MULXSU = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LO_ISSUE = 3'd1,
    LO_WAIT  = 3'd2,
    LO_CAPT  = 3'd3,
    HI_ISSUE = 3'd4,
    HI_WAIT  = 3'd5,
    HI_CAPT  = 3'd6,
    DONE     = 3'd7
  } mul_state_e;

  // p1 + ((p2 + p3) << 16) for 16x16 partial products never exceeds 49 bits.
  localparam int ACC_W = 49;

endpackage

// File: rtl/cpu_mul_hi_fix.sv
// Signed correction of the unsigned high product word for MULXSS / MULXSU (macro CPU_MUL_MULX_EN).
// Latency: purely combinational.
// Backpressure: none; the caller samples the result when it needs it.
`ifdef CPU_MUL_MULX_EN
module cpu_mul_hi_fix
  import cpu_mul_pkg::*;
(
  input  logic [31:0] hu,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] res
);

  // A negative operand contributes an extra -(other operand) << 32 to the product.
  always_comb begin
    res = hu;
    if ((op == MUL_OP_MULXSS || op == MUL_OP_MULXSU) && a[31]) begin
      res = res - b;
    end
    if (op == MUL_OP_MULXSS && b[31]) begin
      res = res - a;
    end
  end

endmodule
`endif

// File: rtl/cpu_mul_seq.sv
// Drives the registered 16x16 partial-product cell and assembles MUL / MULX* results (macro CPU_MUL_MULX_EN).
// Latency: accept cycle to rsp_valid is 2+L for MUL, 3+2L for MULX* (L = CELL_LATENCY, 1..3).
// Backpressure: one op in flight; req_ready only in IDLE, result held in DONE until rsp_ready.
module cpu_mul_seq
  import cpu_mul_pkg::*;
#(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);

  // Wait cycles after an issue; with L=1 the CAPT state follows the issue directly.
  localparam logic [1:0] WAIT_INIT = 2'(CELL_LATENCY - 1);

  mul_state_e        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       src1_q, src1_d;
  logic [31:0]       src2_q, src2_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic [32:0]       mid_w;
  logic [ACC_W-1:0]  acc_w;

  // Low-pass assembly: everything below a_hi*b_hi, valid only while in LO_CAPT.
  assign mid_w = {1'b0, cell_p2} + {1'b0, cell_p3};
  assign acc_w = {17'b0, cell_p1} + {mid_w, 16'b0};

`ifdef CPU_MUL_MULX_EN
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [31:0]       hu_w;
  logic [31:0]       hi_res_w;

  // In HI_CAPT the cell's p1 holds a_hi*b_hi; add the carry-out of the low pass.
  assign hu_w = cell_p1 + {15'b0, acc_q[ACC_W-1:32]};

  cpu_mul_hi_fix u_hi_fix (
    .hu  (hu_w),
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (hi_res_w)
  );
`else
  // Without the high pass the upper accumulator bits have no consumer.
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_w[ACC_W-1:32];
`endif

  assign cell_src1 = src1_q;
  assign cell_src2 = src2_q;
  assign rsp_data  = rsp_data_q;

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    rsp_data_d = rsp_data_q;
`ifdef CPU_MUL_MULX_EN
    acc_d      = acc_q;
`endif
    req_ready  = (state_q == IDLE) && !reset;
    cell_en    = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          src1_d  = req_a;
          src2_d  = req_b;
          state_d = LO_ISSUE;
        end
      end
      LO_ISSUE: begin
        cell_en = 1'b1;
        cnt_d   = WAIT_INIT;
        state_d = (CELL_LATENCY > 1) ? LO_WAIT : LO_CAPT;
      end
      LO_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = LO_CAPT;
        end
      end
      LO_CAPT: begin
        if (op_q == MUL_OP_MUL) begin
          rsp_data_d = acc_w[31:0];
          state_d    = DONE;
        end else begin
`ifdef CPU_MUL_MULX_EN
          acc_d   = acc_w;
          src1_d  = {16'h0, a_q[31:16]};
          src2_d  = {16'h0, b_q[31:16]};
          state_d = HI_ISSUE;
`else
          rsp_data_d = 32'h0;
          state_d    = DONE;
`endif
        end
      end
`ifdef CPU_MUL_MULX_EN
      HI_ISSUE: begin
        cell_en = 1'b1;
        cnt_d   = WAIT_INIT;
        state_d = (CELL_LATENCY > 1) ? HI_WAIT : HI_CAPT;
      end
      HI_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = HI_CAPT;
        end
      end
      HI_CAPT: begin
        rsp_data_d = hi_res_w;
        state_d    = DONE;
      end
`endif
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 2'b0;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      cnt_q      <= 2'b0;
      src1_q     <= 32'h0;
      src2_q     <= 32'h0;
      rsp_data_q <= 32'h0;
`ifdef CPU_MUL_MULX_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      rsp_data_q <= rsp_data_d;
`ifdef CPU_MUL_MULX_EN
      acc_q      <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Bench for cpu_mul_seq: three instances with CELL_LATENCY 1, 2 and 3, each with its own cell model.
// Latency: expected latencies come from the op class and L, checked per transaction.
// Backpressure: rsp_ready held low on one transaction while a second request waits.
module tb_cpu_mul_seq;

  localparam int N = 3;
`ifdef CPU_MUL_MULX_EN
  localparam bit MULX_ON = 1'b1;
`else
  localparam bit MULX_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [N];
  logic        req_ready [N];
  logic [1:0]  req_op    [N];
  logic [31:0] req_a     [N];
  logic [31:0] req_b     [N];
  logic [31:0] cell_src1 [N];
  logic [31:0] cell_src2 [N];
  logic        cell_en   [N];
  logic [31:0] cell_p1   [N];
  logic [31:0] cell_p2   [N];
  logic [31:0] cell_p3   [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_data  [N];
  logic        busy      [N];

  int total = 0;
  int bad = 0;

  logic [31:0] e_data;
  logic [31:0] e_s1;
  logic [31:0] e_s2;
  int          e_lat;
  int          e_pulses;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int L = g + 1;
    logic [31:0] po1 = 32'h0, po2 = 32'h0, po3 = 32'h0;
    logic [31:0] pd1 = 32'h0, pd2 = 32'h0, pd3 = 32'h0;
    int          cd = 0;

    cpu_mul_seq #(.CELL_LATENCY(L)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_op    (req_op[g]),
      .req_a     (req_a[g]),
      .req_b     (req_b[g]),
      .cell_src1 (cell_src1[g]),
      .cell_src2 (cell_src2[g]),
      .cell_en   (cell_en[g]),
      .cell_p1   (cell_p1[g]),
      .cell_p2   (cell_p2[g]),
      .cell_p3   (cell_p3[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .busy      (busy[g])
    );

    // Behavioural cell: products of the enabled operands appear L cycles later and then hold.
    always @(posedge clk) begin
      if (cd == 1) begin
        po1 <= pd1; po2 <= pd2; po3 <= pd3;
      end
      if (cd != 0) cd <= cd - 1;
      if (cell_en[g] === 1'b1) begin
        if (L == 1) begin
          po1 <= {16'h0, cell_src1[g][15:0]}  * {16'h0, cell_src2[g][15:0]};
          po2 <= {16'h0, cell_src1[g][15:0]}  * {16'h0, cell_src2[g][31:16]};
          po3 <= {16'h0, cell_src1[g][31:16]} * {16'h0, cell_src2[g][15:0]};
        end else begin
          pd1 <= {16'h0, cell_src1[g][15:0]}  * {16'h0, cell_src2[g][15:0]};
          pd2 <= {16'h0, cell_src1[g][15:0]}  * {16'h0, cell_src2[g][31:16]};
          pd3 <= {16'h0, cell_src1[g][31:16]} * {16'h0, cell_src2[g][15:0]};
          cd  <= L - 1;
        end
      end
    end

    assign cell_p1[g] = po1;
    assign cell_p2[g] = po2;
    assign cell_p3[g] = po3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Full 64-bit product with the operand signedness each op implies.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = {32'h0, a};
    xb = {32'h0, b};
    if (op == 2'd2 || op == 2'd3) xa = {{32{a[31]}}, a};
    if (op == 2'd2) xb = {{32{b[31]}}, b};
    p = xa * xb;
    if (op == 2'd0) return p[31:0];
    return p[63:32];
  endfunction

  task automatic set_exp(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int  lat;
    bit  hi;
    lat = k + 1;
    hi  = (op != 2'd0) && MULX_ON;
    e_data   = (op != 2'd0 && !MULX_ON) ? 32'h0 : ref_res(op, a, b);
    e_lat    = hi ? (3 + 2 * lat) : (2 + lat);
    e_pulses = hi ? 2 : 1;
    e_s1     = {16'h0, a[31:16]};
    e_s2     = {16'h0, b[31:16]};
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic start(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    set_exp(k, op, a, b);
    req_valid[k] = 1'b1;
    req_op[k]    = op;
    req_a[k]     = a;
    req_b[k]     = b;
    while (req_ready[k] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", {31'b0, req_ready[k]}, 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic collect(input int k, input string tag);
    int          n;
    int          pulses;
    logic [31:0] s1, s2;
    n = 1;
    pulses = 0;
    s1 = 32'h0;
    s2 = 32'h0;
    while (rsp_valid[k] !== 1'b1 && n < 60) begin
      if (cell_en[k] === 1'b1) begin
        pulses++;
        s1 = cell_src1[k];
        s2 = cell_src2[k];
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(e_lat));
    chk({tag, "_data"}, rsp_data[k], e_data);
    chk({tag, "_pulses"}, 32'(pulses), 32'(e_pulses));
    if (e_pulses == 2) begin
      chk({tag, "_hi_src1"}, s1, e_s1);
      chk({tag, "_hi_src2"}, s2, e_s2);
    end
  endtask

  task automatic release_rsp(input int k, input string tag);
    @(negedge clk);
    chk({tag, "_vld_drop"}, {31'b0, rsp_valid[k]}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy[k]}, 32'd0);
  endtask

  initial begin
    int          rk;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          seen;

    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      req_op[k]    = 2'd0;
      req_a[k]     = 32'h0;
      req_b[k]     = 32'h0;
      rsp_ready[k] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("rst_req_ready", {31'b0, req_ready[k]}, 32'd0);
      chk("rst_busy", {31'b0, busy[k]}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid[k]}, 32'd0);
      chk("rst_cell_en", {31'b0, cell_en[k]}, 32'd0);
      chk("rst_src1", cell_src1[k], 32'h0);
      chk("rst_src2", cell_src2[k], 32'h0);
      chk("rst_rsp_data", rsp_data[k], 32'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) chk("idle_req_ready", {31'b0, req_ready[k]}, 32'd1);

    // Directed ops from the plan.
    start(0, 2'd0, 32'h00010003, 32'h00020005); collect(0, "mul_l1");    release_rsp(0, "mul_l1");
    start(1, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); collect(1, "mulxuu_l2"); release_rsp(1, "mulxuu_l2");
    start(0, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); collect(0, "mulxss");    release_rsp(0, "mulxss");
    start(0, 2'd3, 32'hFFFFFFFF, 32'h00000002); collect(0, "mulxsu");    release_rsp(0, "mulxsu");
    start(2, 2'd2, 32'h80000000, 32'h7FFFFFFF); collect(2, "mulxss_l3"); release_rsp(2, "mulxss_l3");

    // Result held in DONE while a second request waits.
    rsp_ready[0] = 1'b0;
    start(0, 2'd1, 32'h12345678, 32'h9ABCDEF0);
    collect(0, "hold");
    req_valid[0] = 1'b1;
    req_op[0]    = 2'd0;
    req_a[0]     = 32'd7;
    req_b[0]     = 32'd9;
    repeat (5) begin
      @(negedge clk);
      chk("hold_vld", {31'b0, rsp_valid[0]}, 32'd1);
      chk("hold_data", rsp_data[0], e_data);
      chk("hold_req_ready", {31'b0, req_ready[0]}, 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("hold_vld_drop", {31'b0, rsp_valid[0]}, 32'd0);
    chk("pend_req_ready", {31'b0, req_ready[0]}, 32'd1);
    set_exp(0, 2'd0, 32'd7, 32'd9);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("pend_busy", {31'b0, busy[0]}, 32'd1);
    collect(0, "pend");
    release_rsp(0, "pend");

    // Reset during LO_WAIT on the L=3 instance.
    start(2, 2'd0, 32'h00001234, 32'h00005678);
    @(negedge clk);
    chk("wait_busy", {31'b0, busy[2]}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, busy[2]}, 32'd0);
    chk("mid_rst_cell_en", {31'b0, cell_en[2]}, 32'd0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid[2]}, 32'd0);
    chk("mid_rst_req_ready", {31'b0, req_ready[2]}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[2] === 1'b1) seen = 1'b1;
    end
    chk("no_rsp_after_rst", {31'b0, seen}, 32'd0);
    start(2, 2'd0, 32'd7, 32'd6); collect(2, "after_rst"); release_rsp(2, "after_rst");

    // Randomized ops across all latencies.
    for (int i = 0; i < 40; i++) begin
      rk  = $urandom_range(0, N - 1);
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'h0000FFFF;
      start(rk, rop, ra, rb);
      collect(rk, "rand");
      release_rsp(rk, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
